// File: rtl/micro_pkg.sv
// micro_pkg: opcode/state encodings, instruction field positions and the flag
// bundle shared by micro_core_p and its iterative divider.
package micro_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_ADD  = 4'h1, OP_LDI  = 4'h2, OP_SUB  = 4'h3,
    OP_ADI  = 4'h4, OP_DIV  = 4'h5, OP_MUL  = 4'h6, OP_DEC  = 4'h7,
    OP_INC  = 4'h8, OP_NOR  = 4'h9, OP_NAND = 4'hA, OP_XOR  = 4'hB,
    OP_COMP = 4'hC, OP_CJMP = 4'hD, OP_JMP  = 4'hE, OP_HLT  = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IF = 3'd0, ST_FD = 3'd1, ST_EX = 3'd2, ST_RWB = 3'd3, ST_HALT = 3'd4
  } state_e;

  localparam int OP_LSB  = 12;
  localparam int RA_LSB  = 8;
  localparam int RB_LSB  = 4;
  localparam int RD_LSB  = 0;
  localparam int FIELD_W = 4;

  typedef struct packed {
    logic cout;
    logic of;
    logic z;
    logic dz;
  } flags_t;

endpackage

// File: rtl/micro_div_iter.sv
// micro_div_iter: restoring divider, one quotient bit per cycle after a load
// cycle. A zero divisor is answered combinationally on start (all-ones, dz).
module micro_div_iter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic              dz
);

  localparam int CW = $clog2(DATA_W + 1);

  logic              busy_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q;
  logic [DATA_W:0]   rem_sh, diff;

  // Remainder always stays below the divisor, so DATA_W bits hold it and the
  // top bit of diff is a clean borrow.
  always_comb begin
    rem_sh = {rem_q, quo_q[DATA_W-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    rem_d  = rem_sh[DATA_W-1:0];
    quo_d  = {quo_q[DATA_W-2:0], 1'b0};
    if (!diff[DATA_W]) begin
      rem_d = diff[DATA_W-1:0];
      quo_d = {quo_q[DATA_W-2:0], 1'b1};
    end
  end

  assign dz       = start && (divisor == '0);
  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == CW'(1));
  assign quotient = dz ? '1 : quo_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else if (start && !dz) begin
      busy_q <= 1'b1;
      cnt_q  <= CW'(DATA_W);
      rem_q  <= '0;
      quo_q  <= dividend;
      dvs_q  <= divisor;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/micro_core_p.sv
// micro_core_p: multicycle IF/FD/EX/RWB core with fetch handshake and HALT.
// Define MICRO_DIV_EN to make opcode 5 an iterative divide; otherwise it is a NOP.
module micro_core_p
  import micro_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_ack,
  input  logic              resume,
  output logic [3:0]        OPCODE,
  output logic [2:0]        state,
  output logic [PC_W-1:0]   PC,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] W_Reg,
  output logic              Cout,
  output logic              OF,
  output logic              Z,
  output logic              DZ,
  output logic              halted
);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_next;
  logic [15:0]         ir_q;
  logic [DATA_W-1:0]   a_q, b_q, w_q;
  flags_t              flg_q, flg_d;
  logic [DATA_W-1:0]   rf_q [2**REG_AW];

  opcode_e             op;
  logic [REG_AW-1:0]   ra_idx, rb_idx, rd_idx;
  logic [DATA_W-1:0]   opa, opb, res;
  logic [DATA_W:0]     sum;
  logic                cin, add_of, is_arith, is_alu, ex_done;
  logic [DATA_W-1:0]   div_q;
  logic                div_done, div_dz;

  assign op     = opcode_e'(ir_q[OP_LSB +: FIELD_W]);
  assign ra_idx = ir_q[RA_LSB +: REG_AW];
  assign rb_idx = ir_q[RB_LSB +: REG_AW];
  assign rd_idx = ir_q[RD_LSB +: REG_AW];

`ifdef MICRO_DIV_EN
  localparam bit DIV_EN = 1'b1;
  logic div_start, div_busy;
  assign div_start = (state_q == ST_EX) && (op == OP_DIV) && !div_busy;
  micro_div_iter #(.DATA_W(DATA_W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (a_q),
    .divisor  (b_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q),
    .dz       (div_dz)
  );
`else
  localparam bit DIV_EN = 1'b0;
  assign div_q    = '0;
  assign div_done = 1'b0;
  assign div_dz   = 1'b0;
`endif

  assign is_alu   = (op >= OP_ADD) && (op <= OP_COMP) && (DIV_EN || op != OP_DIV);
  assign is_arith = (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADI) ||
                    (op == OP_DEC) || (op == OP_INC);
  assign ex_done  = !(DIV_EN && op == OP_DIV) || div_dz || div_done;

  // One shared adder; SUB/DEC use A+~B+1 so the carry reads as no-borrow.
  always_comb begin
    opa = a_q;
    opb = b_q;
    cin = 1'b0;
    case (op)
      OP_SUB:  begin opb = ~b_q; cin = 1'b1; end
      OP_ADI:  opb = DATA_W'(ir_q[RB_LSB +: FIELD_W]);
      OP_DEC:  begin opa = b_q; opb = ~DATA_W'(1); cin = 1'b1; end
      OP_INC:  begin opa = b_q; opb = '0; cin = 1'b1; end
      default: ;
    endcase
    sum    = {1'b0, opa} + {1'b0, opb} + {{DATA_W{1'b0}}, cin};
    add_of = (opa[DATA_W-1] == opb[DATA_W-1]) && (sum[DATA_W-1] != opa[DATA_W-1]);

    case (op)
      OP_ADD, OP_SUB, OP_ADI, OP_DEC, OP_INC: res = sum[DATA_W-1:0];
      OP_LDI:  res = DATA_W'(ir_q[RB_LSB +: 2*FIELD_W]);
      OP_DIV:  res = div_q;
      OP_MUL:  res = a_q * b_q;
      OP_NOR:  res = ~(a_q | b_q);
      OP_NAND: res = ~(a_q & b_q);
      OP_XOR:  res = a_q ^ b_q;
      OP_COMP: res = ~b_q;
      default: res = '0;
    endcase

    flg_d = flg_q;
    if (is_alu) begin
      flg_d.cout = is_arith && sum[DATA_W];
      flg_d.of   = is_arith && add_of;
      flg_d.z    = (res == '0);
      if (op == OP_DIV) flg_d.dz = div_dz;
    end
  end

  always_comb begin
    pc_next = pc_q + PC_W'(1);
    case (op)
      OP_CJMP: if (a_q >= b_q) pc_next = pc_q + PC_W'(ir_q[RD_LSB +: FIELD_W]);
      OP_JMP:  pc_next = PC_W'(ir_q[RB_LSB +: 2*FIELD_W]);
      OP_HLT:  pc_next = pc_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IF;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    case (state_q)
      ST_IF: begin
        imem_req = !reset;
        if (imem_ack) state_d = ST_FD;
      end
      ST_FD:   state_d = ST_EX;
      ST_EX:   if (ex_done) state_d = ST_RWB;
      ST_RWB:  state_d = (op == OP_HLT) ? ST_HALT : ST_IF;
      ST_HALT: if (resume) state_d = ST_IF;
      default: state_d = ST_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= '0;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      w_q   <= '0;
      flg_q <= '0;
      for (int i = 0; i < 2**REG_AW; i++) rf_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IF: if (imem_ack) ir_q <= imem_rdata;
        ST_FD: begin
          a_q <= rf_q[ra_idx];
          b_q <= rf_q[rb_idx];
        end
        ST_EX: if (ex_done) begin
          if (is_alu) w_q <= res;
          flg_q <= flg_d;
        end
        ST_RWB: begin
          pc_q <= pc_next;
          if (is_alu) rf_q[rd_idx] <= w_q;
        end
        ST_HALT: if (resume) pc_q <= pc_q + PC_W'(1);
        default: ;
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign PC        = pc_q;
  assign OPCODE    = ir_q[OP_LSB +: FIELD_W];
  assign state     = state_q;
  assign alu_out   = (state_q == ST_EX) ? res : '0;
  assign W_Reg     = w_q;
  assign Cout      = flg_q.cout;
  assign OF        = flg_q.of;
  assign Z         = flg_q.z;
  assign DZ        = DIV_EN && flg_q.dz;
  assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_micro_core_p.sv
// tb_micro_core_p: directed programs plus random programs against an
// instruction-level reference model of micro_core_p.
module tb_micro_core_p;

  localparam int DW = 8;
  localparam int PW = 8;
  localparam int RAW = 4;
  localparam longint M    = longint'(1) << DW;
  localparam longint HALF = M / 2;
  localparam longint PCM  = longint'(1) << PW;
`ifdef MICRO_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1, imem_ack = 1'b0, resume = 1'b0;
  logic imem_req, Cout, OF, Z, DZ, halted;
  logic [PW-1:0] imem_addr, PC;
  logic [15:0] imem_rdata;
  logic [3:0] OPCODE;
  logic [2:0] state;
  logic [DW-1:0] alu_out, W_Reg;

  logic [15:0] imem [256];
  int checks = 0, errors = 0;

  longint m_rf [16];
  longint m_pc;
  logic [3:0] m_f;

  assign imem_rdata = imem[imem_addr];
  always #5 clk = ~clk;

  micro_core_p #(.DATA_W(DW), .PC_W(PW), .REG_AW(RAW)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .resume(resume),
    .OPCODE(OPCODE), .state(state), .PC(PC), .alu_out(alu_out), .W_Reg(W_Reg),
    .Cout(Cout), .OF(OF), .Z(Z), .DZ(DZ), .halted(halted)
  );

  function automatic longint sgn(input longint x);
    return (x >= HALF) ? x - M : x;
  endfunction

  function automatic logic ovf(input longint s);
    return (s >= HALF) || (s < -HALF);
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = 0;
    m_pc = 0;
    m_f  = 4'b0000;
  endtask

  task automatic apply_reset();
    reset = 1'b1; imem_ack = 1'b0; resume = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL reset_req: got %b want 0", imem_req);
    end
    checks++;
    if ({state, PC, W_Reg, OPCODE, Cout, OF, Z, DZ, halted} !== {3'd0, {PW{1'b0}}, {DW{1'b0}}, 4'h0, 5'b0}) begin
      errors++;
      $display("FAIL reset_vals: state=%0d pc=%0h w=%0h op=%0h flags=%b halted=%b want all 0",
               state, PC, W_Reg, OPCODE, {Cout, OF, Z, DZ}, halted);
    end
    reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  // Executes the instruction at m_pc with `stall` ack-less IF cycles; a HLT is
  // held for `hold` extra cycles before a resume pulse.
  task automatic exec_one(input int stall, input int hold);
    logic [15:0] ir;
    logic [3:0] op;
    longint a, b, r, nx, rbv, rdv;
    logic c, o, dz, alu;
    logic [3:0] f;
    int ex, n;
    ir  = imem[m_pc[PW-1:0]];
    op  = ir[15:12];
    a   = m_rf[ir[8 +: RAW]];
    b   = m_rf[ir[4 +: RAW]];
    rbv = ir[7:4];
    rdv = ir[3:0];
    r = 0; c = 1'b0; o = 1'b0; dz = m_f[0]; alu = 1'b1; ex = 1;
    case (op)
      4'h1: begin r = a + b; c = (r >= M); o = ovf(sgn(a) + sgn(b)); end
      4'h2: r = ir[11:4];
      4'h3: begin r = a - b; c = (a >= b); o = ovf(sgn(a) - sgn(b)); end
      4'h4: begin r = a + rbv; c = (r >= M); o = ovf(sgn(a) + sgn(rbv)); end
      4'h5: begin
        if (!DIV_EN) alu = 1'b0;
        else if (b == 0) begin r = M - 1; dz = 1'b1; end
        else begin r = a / b; dz = 1'b0; ex = DW + 1; end
      end
      4'h6: r = a * b;
      4'h7: begin r = b - 1; c = (b >= 1); o = ovf(sgn(b) - 1); end
      4'h8: begin r = b + 1; c = (r >= M); o = ovf(sgn(b) + 1); end
      4'h9: r = ~(a | b);
      4'hA: r = ~(a & b);
      4'hB: r = a ^ b;
      4'hC: r = ~b;
      default: alu = 1'b0;
    endcase
    r = r & (M - 1);
    f = alu ? {c, o, (r == 0), dz} : m_f;
    nx = (m_pc + 1) % PCM;
    if (op == 4'hD && a >= b) nx = (m_pc + rdv) % PCM;
    if (op == 4'hE) begin nx = ir[11:4]; nx = nx % PCM; end

    checks++;
    if (state !== 3'd0 || imem_req !== 1'b1 || imem_addr !== m_pc[PW-1:0]) begin
      errors++;
      $display("FAIL fetch_req: state=%0d req=%b addr=%0h want state=0 req=1 addr=%0h",
               state, imem_req, imem_addr, m_pc[PW-1:0]);
    end
    imem_ack = 1'b0;
    repeat (stall) @(negedge clk);
    if (stall > 0) begin
      checks++;
      if (state !== 3'd0 || imem_req !== 1'b1 || PC !== m_pc[PW-1:0]) begin
        errors++;
        $display("FAIL fetch_stall: state=%0d req=%b pc=%0h want 0/1/%0h", state, imem_req, PC, m_pc[PW-1:0]);
      end
    end
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (state !== 3'd1 || OPCODE !== op) begin
      errors++; $display("FAIL decode: state=%0d op=%0h want 1/%0h", state, OPCODE, op);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1 && alu && ex == 1) begin
        checks++;
        if (alu_out !== r[DW-1:0]) begin
          errors++; $display("FAIL alu_out ir=%04h: got %0h want %0h", ir, alu_out, r[DW-1:0]);
        end
      end
    end while (state !== 3'd3 && n < 64);
    checks++;
    if (n !== ex + 1) begin
      errors++; $display("FAIL ex_cycles ir=%04h: got %0d want %0d", ir, n - 1, ex);
    end
    checks++;
    if ({Cout, OF, Z, DZ} !== f) begin
      errors++; $display("FAIL flags ir=%04h a=%0h b=%0h: got %b want %b", ir, a, b, {Cout, OF, Z, DZ}, f);
    end
    if (alu) begin
      checks++;
      if (W_Reg !== r[DW-1:0]) begin
        errors++; $display("FAIL w_reg ir=%04h a=%0h b=%0h: got %0h want %0h", ir, a, b, W_Reg, r[DW-1:0]);
      end
      m_rf[ir[0 +: RAW]] = r;
    end
    @(negedge clk);
    if (op == 4'hF) begin
      checks++;
      if (state !== 3'd4 || halted !== 1'b1 || PC !== m_pc[PW-1:0]) begin
        errors++; $display("FAIL halt_enter: state=%0d halted=%b pc=%0h want 4/1/%0h", state, halted, PC, m_pc[PW-1:0]);
      end
      repeat (hold) @(negedge clk);
      checks++;
      if (state !== 3'd4 || halted !== 1'b1 || PC !== m_pc[PW-1:0]) begin
        errors++; $display("FAIL halt_hold: state=%0d halted=%b pc=%0h want 4/1/%0h", state, halted, PC, m_pc[PW-1:0]);
      end
      resume = 1'b1;
      @(negedge clk);
      resume = 1'b0;
      nx = (m_pc + 1) % PCM;
      checks++;
      if (state !== 3'd0 || halted !== 1'b0 || PC !== nx[PW-1:0]) begin
        errors++; $display("FAIL resume: state=%0d halted=%b pc=%0h want 0/0/%0h", state, halted, PC, nx[PW-1:0]);
      end
    end else begin
      checks++;
      if (state !== 3'd0 || PC !== nx[PW-1:0]) begin
        errors++; $display("FAIL next_pc ir=%04h: state=%0d pc=%0h want 0/%0h", ir, state, PC, nx[PW-1:0]);
      end
    end
    m_pc = nx;
    m_f  = f;
  endtask

  task automatic test_reset();
    clear_imem();
    apply_reset();
  endtask

  task automatic test_add_overflow();
    clear_imem();
    imem[0] = 16'h27F0; imem[1] = 16'h2011; imem[2] = 16'h1012;
    apply_reset();
    repeat (3) exec_one(0, 0);
    checks++;
    if (W_Reg !== 8'h80 || {Cout, OF, Z} !== 3'b010) begin
      errors++; $display("FAIL add_7f_01: w=%0h cof z=%b want 80/010", W_Reg, {Cout, OF, Z});
    end
  endtask

  task automatic test_sub();
    clear_imem();
    imem[0] = 16'h2053; imem[1] = 16'h2074; imem[2] = 16'h3345; imem[3] = 16'h3436;
    apply_reset();
    repeat (3) exec_one(0, 0);
    checks++;
    if (W_Reg !== 8'hFE || {Cout, OF} !== 2'b00) begin
      errors++; $display("FAIL sub_5_7: w=%0h c/of=%b want fe/00", W_Reg, {Cout, OF});
    end
    exec_one(0, 0);
    checks++;
    if (W_Reg !== 8'h02 || Cout !== 1'b1) begin
      errors++; $display("FAIL sub_7_5: w=%0h c=%b want 02/1", W_Reg, Cout);
    end
  endtask

  task automatic test_div();
    clear_imem();
    imem[0] = 16'h2641; imem[1] = 16'h2072; imem[2] = 16'h5123;
    imem[3] = 16'h5104; imem[4] = 16'h1305;
    apply_reset();
    repeat (3) exec_one(0, 0);
    checks++;
    if (W_Reg !== (DIV_EN ? 8'h0E : 8'h07) || DZ !== 1'b0) begin
      errors++; $display("FAIL div_100_7: w=%0h dz=%b want %0h/0", W_Reg, DZ, DIV_EN ? 8'h0E : 8'h07);
    end
    exec_one(0, 0);
    checks++;
    if (W_Reg !== (DIV_EN ? 8'hFF : 8'h07) || DZ !== DIV_EN) begin
      errors++; $display("FAIL div_by_0: w=%0h dz=%b want %0h/%b", W_Reg, DZ, DIV_EN ? 8'hFF : 8'h07, DIV_EN);
    end
    exec_one(0, 0);
  endtask

  task automatic test_fetch_stall();
    clear_imem();
    imem[0] = 16'h2051; imem[1] = 16'h8112;
    apply_reset();
    exec_one(3, 0);
    exec_one(1, 0);
  endtask

  task automatic test_branches();
    clear_imem();
    imem[0] = 16'h20A1; imem[1] = 16'h2022; imem[4] = 16'hD126;
    imem[10] = 16'hD216; imem[11] = 16'hE040;
    apply_reset();
    repeat (5) exec_one(0, 0);
    checks++;
    if (PC !== 8'h0A) begin errors++; $display("FAIL cjmp_taken: pc=%0h want 0a", PC); end
    exec_one(0, 0);
    checks++;
    if (PC !== 8'h0B) begin errors++; $display("FAIL cjmp_not_taken: pc=%0h want 0b", PC); end
    exec_one(0, 0);
    checks++;
    if (PC !== 8'h04) begin errors++; $display("FAIL jmp_e040: pc=%0h want 04", PC); end
    imem[4] = 16'hD216;
    exec_one(0, 0);
    checks++;
    if (PC !== 8'h05) begin errors++; $display("FAIL cjmp_at4_lt: pc=%0h want 05", PC); end
  endtask

  task automatic test_halt_resume();
    clear_imem();
    imem[0] = 16'hE140; imem[20] = 16'hF000; imem[21] = 16'h2AA1;
    apply_reset();
    exec_one(0, 0);
    exec_one(0, 10);
    checks++;
    if (PC !== 8'h15) begin errors++; $display("FAIL halt_pc: pc=%0h want 15", PC); end
    exec_one(0, 0);
  endtask

  task automatic test_reset_mid_div();
    clear_imem();
    imem[0] = 16'h2FF1; imem[1] = 16'h2073; imem[2] = 16'h1114; imem[3] = 16'h5134;
    apply_reset();
    repeat (3) exec_one(0, 0);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    if (DIV_EN) repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({state, PC, W_Reg, Cout, OF, Z, DZ} !== {3'd0, {PW{1'b0}}, {DW{1'b0}}, 4'b0}) begin
      errors++;
      $display("FAIL reset_mid_div: state=%0d pc=%0h w=%0h flags=%b want all 0", state, PC, W_Reg, {Cout, OF, Z, DZ});
    end
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    repeat (4) exec_one(0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) imem[i] = 16'($urandom);
    apply_reset();
    for (int i = 0; i < 300; i++) exec_one($urandom_range(0, 2), $urandom_range(0, 3));
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub();
    test_div();
    test_fetch_stall();
    test_branches();
    test_halt_resume();
    test_reset_mid_div();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
